// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared arbiter state encoding and master indices.
// Contents: arb_state_e (ARB, LOCK0, LOCK1), M_IFETCH / M_LSU requester indices.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_e;

    localparam int M_IFETCH = 0;
    localparam int M_LSU    = 1;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: stateless 2-way round-robin picker.
// Ports: req[1:0] raw requests, last_gnt index of the last granted master,
//        mask[1:0] eligible masters, gnt[1:0] one-hot winner (or 0).
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    input  logic [1:0] mask,
    output logic [1:0] gnt
);

    logic [1:0] r;

    assign r = req & mask;

    // On a tie the master that did not win last time takes the slot.
    assign gnt[M_IFETCH] = r[M_IFETCH] & (!r[M_LSU] | last_gnt);
    assign gnt[M_LSU]    = r[M_LSU] & (!r[M_IFETCH] | !last_gnt);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port-per-direction memory between
// instruction fetch (m0) and load/store (m1) with round-robin and locking.
// Ports: clk, rst (async, active-low); per master mN_req/we/lock/addr/wdata in,
//        mN_gnt (combinational), mN_rvalid (registered), mN_rdata out;
//        memory side mem_re/raddr/rdata and mem_we/waddr/wdata.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AWIDTH = 16,
    parameter int DWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic              m0_lock,
    input  logic [AWIDTH-1:0] m0_addr,
    input  logic [DWIDTH-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DWIDTH-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic              m1_lock,
    input  logic [AWIDTH-1:0] m1_addr,
    input  logic [DWIDTH-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DWIDTH-1:0] m1_rdata,
    output logic              mem_re,
    output logic [AWIDTH-1:0] mem_raddr,
    input  logic [DWIDTH-1:0] mem_rdata,
    output logic              mem_we,
    output logic [AWIDTH-1:0] mem_waddr,
    output logic [DWIDTH-1:0] mem_wdata
);

    arb_state_e  state_q, state_d;
    logic        last_q, last_d;
    logic [1:0]  rd_pend_q, rd_pend_d;
    logic [1:0]  mask, pick, gnt;
    logic        any, sel, sel_we, sel_lock;

    always_comb mask = (state_q == LOCK0) ? 2'b01 : (state_q == LOCK1) ? 2'b10 : 2'b11;

    rr_arb2 u_pick (
        .req      ({m1_req, m0_req}),
        .last_gnt (last_q),
        .mask     (mask),
        .gnt      (pick)
    );

    // Grants are suppressed combinationally while reset is held.
    assign gnt      = rst ? pick : 2'b00;
    assign any      = |gnt;
    assign sel      = gnt[M_LSU];
    assign sel_we   = sel ? m1_we : m0_we;
    assign sel_lock = sel ? m1_lock : m0_lock;

    assign m0_gnt    = gnt[M_IFETCH];
    assign m1_gnt    = gnt[M_LSU];
    assign mem_re    = any & !sel_we;
    assign mem_we    = any & sel_we;
    assign mem_raddr = sel ? m1_addr : m0_addr;
    assign mem_waddr = sel ? m1_addr : m0_addr;
    assign mem_wdata = sel ? m1_wdata : m0_wdata;

    assign m0_rvalid = rd_pend_q[M_IFETCH];
    assign m1_rvalid = rd_pend_q[M_LSU];
    assign m0_rdata  = mem_rdata;
    assign m1_rdata  = mem_rdata;

    // A grant always decides the next state: a locking access keeps (or takes)
    // ownership, a non-locking one returns to open arbitration.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        rd_pend_d = gnt & ~{m1_we, m0_we};
        if (any) begin
            last_d  = sel;
            state_d = sel_lock ? (sel ? LOCK1 : LOCK0) : ARB;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ARB;
            last_q    <= 1'b1;
            rd_pend_q <= 2'b00;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            rd_pend_q <= rd_pend_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench with a transaction-level model of mem_arbiter.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req [2];
    logic        we  [2];
    logic        lock[2];
    logic [15:0] addr[2];
    logic [15:0] wdat[2];
    logic        gnt [2];
    logic        rv  [2];
    logic [15:0] rd  [2];
    logic        mem_re, mem_we;
    logic [15:0] mem_raddr, mem_waddr, mem_wdata;
    logic [15:0] mem_rdata = 16'h0;

    int vectors = 0;
    int misses  = 0;

    logic [15:0] mem  [256];
    logic [15:0] mmem [256];

    int          owner = -1;
    int          last  = 1;
    logic        pv[2] = '{1'b0, 1'b0};
    logic [15:0] pdata = 16'h0;
    int          win   = -1;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req(req[0]), .m0_we(we[0]), .m0_lock(lock[0]), .m0_addr(addr[0]), .m0_wdata(wdat[0]),
        .m0_gnt(gnt[0]), .m0_rvalid(rv[0]), .m0_rdata(rd[0]),
        .m1_req(req[1]), .m1_we(we[1]), .m1_lock(lock[1]), .m1_addr(addr[1]), .m1_wdata(wdat[1]),
        .m1_gnt(gnt[1]), .m1_rvalid(rv[1]), .m1_rdata(rd[1]),
        .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
    );

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]  = 16'hA000 + 16'(i);
            mmem[i] = 16'hA000 + 16'(i);
        end
        mem[8'h10]  = 16'hBEEF;
        mmem[8'h10] = 16'hBEEF;
    end

    // Behaves like the 1-cycle-latency memory the arbiter fronts.
    always @(posedge clk) begin
        if (mem_we) mem[mem_waddr[7:0]] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_raddr[7:0]];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            misses++;
            $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: who may be granted, who wins a tie, and what read data is owed.
    always @(negedge clk) begin
        bit c0, c1;
        c0  = rst && req[0] && (owner < 0 || owner == 0);
        c1  = rst && req[1] && (owner < 0 || owner == 1);
        win = (c0 && c1) ? 1 - last : c0 ? 0 : c1 ? 1 : -1;
        chk("m0_gnt", 32'(gnt[0]), 32'(win == 0));
        chk("m1_gnt", 32'(gnt[1]), 32'(win == 1));
        chk("mem_re", 32'(mem_re), 32'(win >= 0 && !we[win]));
        chk("mem_we", 32'(mem_we), 32'(win >= 0 && we[win]));
        if (win >= 0 && !we[win]) chk("mem_raddr", 32'(mem_raddr), 32'(addr[win]));
        if (win >= 0 && we[win]) begin
            chk("mem_waddr", 32'(mem_waddr), 32'(addr[win]));
            chk("mem_wdata", 32'(mem_wdata), 32'(wdat[win]));
        end
        chk("m0_rvalid", 32'(rv[0]), 32'(pv[0]));
        chk("m1_rvalid", 32'(rv[1]), 32'(pv[1]));
        if (pv[0]) chk("m0_rdata", 32'(rd[0]), 32'(pdata));
        if (pv[1]) chk("m1_rdata", 32'(rd[1]), 32'(pdata));
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner = -1;
            last  = 1;
            pv    = '{1'b0, 1'b0};
        end else begin
            pv = '{1'b0, 1'b0};
            if (win >= 0) begin
                last  = win;
                owner = lock[win] ? win : -1;
                if (we[win]) mmem[addr[win][7:0]] = wdat[win];
                else begin
                    pv[win] = 1'b1;
                    pdata   = mmem[addr[win][7:0]];
                end
            end
        end
    end

    task automatic drive(input int n, input logic r, input logic w, input logic l,
                         input logic [15:0] a, input logic [15:0] d);
        req[n]  = r;
        we[n]   = w;
        lock[n] = l;
        addr[n] = a;
        wdat[n] = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(0, 0, 0, 0, 16'h0, 16'h0);
        drive(1, 0, 0, 0, 16'h0, 16'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset m0_gnt", 32'(gnt[0]), 32'h0);
        chk("reset m1_rvalid", 32'(rv[1]), 32'h0);
        next_cycle();
        rst = 1'b1;

        drive(0, 1, 0, 0, 16'h0010, 16'h0);
        @(negedge clk);
        chk("rd m0_gnt", 32'(gnt[0]), 32'h1);
        chk("rd mem_re", 32'(mem_re), 32'h1);
        chk("rd mem_raddr", 32'(mem_raddr), 32'h0010);
        next_cycle();
        drive(0, 0, 0, 0, 16'h0, 16'h0);
        @(negedge clk);
        chk("rd m0_rvalid", 32'(rv[0]), 32'h1);
        chk("rd m0_rdata", 32'(rd[0]), 32'hBEEF);
        chk("rd m1_rvalid", 32'(rv[1]), 32'h0);

        next_cycle();
        drive(1, 1, 1, 0, 16'h0200, 16'h1234);
        @(negedge clk);
        chk("wr m1_gnt", 32'(gnt[1]), 32'h1);
        chk("wr mem_we", 32'(mem_we), 32'h1);
        chk("wr mem_waddr", 32'(mem_waddr), 32'h0200);
        chk("wr mem_wdata", 32'(mem_wdata), 32'h1234);
        next_cycle();
        drive(1, 0, 0, 0, 16'h0, 16'h0);
        @(negedge clk);
        chk("wr no rvalid", 32'({rv[1], rv[0]}), 32'h0);

        next_cycle();
        rst = 1'b0;
        next_cycle();
        rst = 1'b1;
        drive(0, 1, 0, 0, 16'h0020, 16'h0);
        drive(1, 1, 0, 0, 16'h0021, 16'h0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("tie m0_gnt", 32'(gnt[0]), 32'(i % 2 == 0));
            chk("tie m1_gnt", 32'(gnt[1]), 32'(i % 2 == 1));
            if (i > 0) chk("tie rvalid", 32'({rv[1], rv[0]}), (i % 2 == 1) ? 32'h1 : 32'h2);
            next_cycle();
        end
        drive(0, 0, 0, 0, 16'h0, 16'h0);
        drive(1, 0, 0, 0, 16'h0, 16'h0);

        next_cycle();
        drive(1, 1, 0, 1, 16'h0040, 16'h0);
        @(negedge clk);
        chk("lock rd m1_gnt", 32'(gnt[1]), 32'h1);
        next_cycle();
        drive(0, 1, 0, 0, 16'h0030, 16'h0);
        drive(1, 1, 1, 1, 16'h0040, 16'h5A5A);
        @(negedge clk);
        chk("lock wr m0_gnt", 32'(gnt[0]), 32'h0);
        chk("lock wr m1_gnt", 32'(gnt[1]), 32'h1);
        next_cycle();
        drive(1, 1, 1, 0, 16'h0040, 16'h6B6B);
        @(negedge clk);
        chk("unlock m0_gnt", 32'(gnt[0]), 32'h0);
        chk("unlock m1_gnt", 32'(gnt[1]), 32'h1);
        next_cycle();
        drive(1, 0, 0, 0, 16'h0, 16'h0);
        @(negedge clk);
        chk("after unlock m0_gnt", 32'(gnt[0]), 32'h1);
        next_cycle();
        drive(0, 0, 0, 0, 16'h0, 16'h0);

        drive(0, 1, 0, 1, 16'h0050, 16'h0);
        @(negedge clk);
        chk("idle lock m0_gnt", 32'(gnt[0]), 32'h1);
        next_cycle();
        drive(0, 0, 0, 0, 16'h0, 16'h0);
        drive(1, 1, 0, 0, 16'h0060, 16'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("idle lock m1_gnt", 32'(gnt[1]), 32'h0);
            next_cycle();
        end
        drive(0, 1, 0, 0, 16'h0051, 16'h0);
        @(negedge clk);
        chk("idle unlock m0_gnt", 32'(gnt[0]), 32'h1);
        chk("idle unlock m1_gnt", 32'(gnt[1]), 32'h0);
        next_cycle();
        drive(0, 0, 0, 0, 16'h0, 16'h0);
        @(negedge clk);
        chk("idle release m1_gnt", 32'(gnt[1]), 32'h1);
        next_cycle();
        drive(1, 0, 0, 0, 16'h0, 16'h0);
        next_cycle();

        drive(0, 1, 0, 0, 16'h0070, 16'h0);
        @(negedge clk);
        chk("rst rd m0_gnt", 32'(gnt[0]), 32'h1);
        #2;
        rst = 1'b0;
        drive(0, 0, 0, 0, 16'h0, 16'h0);
        next_cycle();
        chk("rst drop m0_rvalid", 32'(rv[0]), 32'h0);
        rst = 1'b1;
        drive(0, 1, 0, 0, 16'h0071, 16'h0);
        @(negedge clk);
        chk("rst tie m0_gnt", 32'(gnt[0]), 32'h1);
        next_cycle();
        drive(0, 0, 0, 0, 16'h0, 16'h0);
        #2;
        chk("pend m0_rvalid", 32'(rv[0]), 32'h1);
        rst = 1'b0;
        #1;
        chk("async drop m0_rvalid", 32'(rv[0]), 32'h0);
        next_cycle();
        rst = 1'b1;
        drive(0, 1, 0, 0, 16'h0072, 16'h0);
        drive(1, 1, 0, 0, 16'h0073, 16'h0);
        @(negedge clk);
        chk("post rst tie m0_gnt", 32'(gnt[0]), 32'h1);
        next_cycle();
        drive(0, 0, 0, 0, 16'h0, 16'h0);
        @(negedge clk);
        chk("post rst m1_gnt", 32'(gnt[1]), 32'h1);
        next_cycle();
        drive(1, 0, 0, 0, 16'h0, 16'h0);
        repeat (3) next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one `dpi_memory` instance between two requesters: master 0 (instruction fetch) and master 1 (load/store).
- Grants at most one access per cycle, read or write, and drives the memory's read and write ports.
- Routes the 1-cycle-latency read data back to whichever master issued the read.
- Round-robin fairness; per-master lock for atomic read-modify-write sequences.

Parameters:
AWIDTH, 16, address width; matches the memory's AWIDTH.
DWIDTH, 16, data width; matches the memory's DWIDTH.

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  reset, asynchronous, active-low (0 = in reset)
m0_req  in  1  master 0 access request; held until m0_gnt
m0_we  in  1  1 = write, 0 = read
m0_lock  in  1  keep ownership after this access
m0_addr  in  AWIDTH  access address
m0_wdata  in  DWIDTH  write data
m0_gnt  out  1  access accepted this cycle (combinational)
m0_rvalid  out  1  m0_rdata valid (registered)
m0_rdata  out  DWIDTH  read data
m1_*  same set as m0_*, for master 1
mem_re  out  1  memory read enable
mem_raddr  out  AWIDTH  memory read address
mem_rdata  in  DWIDTH  memory read data, valid 1 cycle after mem_re
mem_we  out  1  memory write enable
mem_waddr  out  AWIDTH  memory write address
mem_wdata  out  DWIDTH  memory write data

Behaviour:
- Handshake: mN_req and its qualifiers stay stable until mN_gnt=1. The transfer occurs in the cycle where req and gnt are both 1.
- gnt is combinational from req, state and the last-grant pointer. At most one gnt is high per cycle.
- While rst=0: all gnt, mem_re and mem_we are forced to 0.
- Memory drive: mem_re = granted & !we; mem_we = granted & we.
  - mem_raddr/mem_waddr/mem_wdata are muxed from the granted master.
  - When nothing is granted these hold master 0's values; this is don't-care because the enables are 0.
- Arbitration in ARB state:
  - Only one master requests: grant it.
  - Both request: grant the master not recorded in last_gnt.
  - last_gnt updates on every grant. Reset value last_gnt=1, so master 0 wins the first tie.
- States: ARB, LOCK0, LOCK1. Reset state is ARB.
  - ARB -> LOCKn on a grant to master n with mN_lock=1.
  - In LOCKn only master n can be granted; the other master's req is ignored, gnt=0.
  - LOCKn -> ARB on a grant to master n with mN_lock=0. That access still executes.
  - LOCKn with no request from n: stay in LOCKn. There is no timeout.
- Read return:
  - rd_pend[1:0] is a registered one-hot flag, set to the index of the master granted a read this cycle, otherwise 0.
  - mN_rvalid = rd_pend[N].
  - m0_rdata = m1_rdata = mem_rdata (broadcast; rvalid qualifies).
  - Latency: gnt on cycle T gives rvalid on T+1. Back-to-back reads give one rvalid per cycle, no bubbles.
- Writes complete in the grant cycle. No response is generated.
- Simultaneous read by one master and write by the other: only one is granted. The loser retries next cycle and wins by round-robin.
- Reset asserted mid-operation: rd_pend, state and last_gnt clear asynchronously. A pending rvalid is dropped (rvalid=0 immediately).
- Reset values: mN_gnt=0, mN_rvalid=0, mem_re=0, mem_we=0.

Decomposition:
- Package mem_arb_pkg:
  - state enum {ARB, LOCK0, LOCK1};
  - localparam master indices M_IFETCH=0, M_LSU=1.
- Sub-module rr_arb2: 2-way round-robin picker.
  - Inputs: req[1:0], last_gnt, mask[1:0].
  - Output: one-hot gnt[1:0].
  - Stateless; the pointer flop stays in mem_arbiter.

Test Plan:
- Single read: m0_req=1, we=0, addr=0x0010, memory returns 0xBEEF -> m0_gnt=1 at T, mem_re=1, mem_raddr=0x0010; m0_rvalid=1, m0_rdata=0xBEEF at T+1; m1_rvalid=0.
- Write path: m1_req=1, we=1, addr=0x0200, wdata=0x1234 -> m1_gnt=1, mem_we=1, mem_waddr=0x0200, mem_wdata=0x1234 same cycle; no rvalid.
- Contention: both masters request reads continuously for 6 cycles after reset -> grants alternate 0,1,0,1,0,1; rvalid alternates one cycle later.
- Lock: m1 read with lock=1 at 0x0040, then m0_req held high while m1 writes 0x0040 with lock=1, then lock=0 -> m0_gnt=0 throughout; state returns to ARB after m1's unlock grant; m0 granted the next cycle.
- Lock idle: m0 grant with lock=1, m0_req drops, m1 requests for 4 cycles -> m1_gnt stays 0 until m0 issues an unlocking access.
- Reset mid-read: m0 read granted at T, rst=0 asserted before edge T+1 -> m0_rvalid=0 at T+1; after release, the first tie grants m0.
